// File: rtl/mmio_uart_ctrl.sv
// MMIO responder for the 0x8000_0000 region: UART TX holding register, RX FIFO, perf counters.
// Counters and the 0x18 clear exist only when MMIO_COUNTERS_EN is defined.
module mmio_uart_ctrl #(
    parameter int RX_FIFO_DEPTH = 8,
    parameter int RX_PTR_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam logic [RX_PTR_W:0] DEPTH_C = (RX_PTR_W+1)'(RX_FIFO_DEPTH);

    logic       hit;
    logic [7:0] off;
    logic       sel_rx, sel_tx;

    assign hit    = addr[31:28] == 4'h8;
    assign off    = addr[7:0];
    assign sel_rx = hit && (off == 8'h04);
    assign sel_tx = hit && (off == 8'h08);

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], addr[27:8]};

    logic [RX_PTR_W:0]   cnt_q, cnt_d;
    logic [RX_PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]          mem_q [RX_FIFO_DEPTH];
    logic                full, empty, push, pop;

    assign full          = cnt_q == DEPTH_C;
    assign empty         = cnt_q == '0;
    assign uart_rx_ready = !full;
    assign push          = uart_rx_valid && !full;
    assign pop           = re && sel_rx && !empty;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= uart_rx_data;
    end

    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;

    // A store landing on the handshake cycle is dropped: status still read busy.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q && uart_tx_ready) begin
            tx_valid_d = 1'b0;
        end else if (we && sel_tx && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = wdata[7:0];
        end
    end

    assign uart_tx_valid = tx_valid_q;
    assign uart_tx_data  = tx_data_q;

`ifdef MMIO_COUNTERS_EN
    logic [31:0] cyc_q, cyc_d, inst_q, inst_d;
    logic        clr;

    assign clr = we && hit && (off == 8'h18);

    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        inst_d = inst_q + {31'd0, inst_retire};
        if (clr) begin
            cyc_d  = '0;
            inst_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            inst_q <= inst_d;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = inst_retire;
`endif

    logic [31:0] rd_val, rdata_q, rdata_d;

    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (off)
                8'h00: rd_val = {30'd0, !empty, !tx_valid_q};
                8'h04: if (!empty) rd_val = {24'd0, mem_q[rd_q]};
`ifdef MMIO_COUNTERS_EN
                8'h10: rd_val = cyc_q;
                8'h14: rd_val = inst_q;
`endif
                default: rd_val = '0;
            endcase
        end
        rdata_d = re ? rd_val : rdata_q;
    end

    assign rdata = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            rdata_q    <= rdata_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

endmodule
